// File: rtl/operand_sequencer_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : operand_sequencer_if
//  Purpose  : Bundles the operand sequencer's button inputs and its operand
//             bus towards the adder.
//  Ports    : btn_step, btn_mode          raw board buttons
//             x, y [WIDTH]                 adder operands
//             c_in                         adder carry-in
//             op_valid, wrap               one-cycle strobes
//             mode_auto                    1 = timed auto-step mode
//  Modports : master - the sequencer (drives the operand bus)
//             slave  - the environment (drives the buttons, consumes operands)
//  Revision : 1.0 - initial release
// ============================================================================
interface operand_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             btn_step;
    logic             btn_mode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c_in;
    logic             op_valid;
    logic             mode_auto;
    logic             wrap;

    modport master (
        input  btn_step,
        input  btn_mode,
        output x,
        output y,
        output c_in,
        output op_valid,
        output mode_auto,
        output wrap
    );

    modport slave (
        output btn_step,
        output btn_mode,
        input  x,
        input  y,
        input  c_in,
        input  op_valid,
        input  mode_auto,
        input  wrap
    );
endinterface
`default_nettype wire

// File: rtl/operand_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : operand_sequencer
//  Purpose  : Stimulus stage for the registered adder. Debounces two board
//             buttons and sweeps every {c_in, y, x} combination, either one
//             step per step-button press (MANUAL) or one step every AUTO_DIV
//             cycles (AUTO). The mode button toggles between the two modes.
//  Ports    : clk             system clock, rising edge
//             rst             synchronous reset, active-high
//             bus (master)    btn_step, btn_mode in; x, y, c_in, op_valid,
//                             mode_auto, wrap out
//  Params   : WIDTH           operand width (2..8), sweep counter is
//                             2*WIDTH+1 bits
//             DEBOUNCE_CYCLES stable cycles required to accept a button
//                             level (>= 2)
//             AUTO_DIV        cycles between steps in AUTO mode (>= 2)
//  Options  : OPSEQ_LFSR_EN   when defined, the sweep counter is a maximal
//                             length Fibonacci LFSR seeded with 1 instead of
//                             a binary counter
//  Revision : 1.0 - initial release
// ============================================================================
module operand_sequencer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int AUTO_DIV        = 12000000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    operand_sequencer_if.master bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_N    = 2 * WIDTH + 1;
    localparam int C_DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int C_PS_W = $clog2(AUTO_DIV);

    localparam logic [C_DB_W-1:0] C_DB_LAST    = C_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_PS_W-1:0] C_PRESC_LAST = C_PS_W'(AUTO_DIV - 1);

`ifdef OPSEQ_LFSR_EN
    // Feedback tap mask per register length: bit (k-1) set for each x^k term
    // of the primitive polynomial (the constant term is implicit).
    function automatic logic [C_N-1:0] tap_mask();
        logic [31:0] m;
        case (C_N)
            5:       m = 32'h0000_0014;   // x^5  + x^3 + 1
            7:       m = 32'h0000_0060;   // x^7  + x^6 + 1
            9:       m = 32'h0000_0110;   // x^9  + x^5 + 1
            11:      m = 32'h0000_0500;   // x^11 + x^9 + 1
            13:      m = 32'h0000_1C80;   // x^13 + x^12 + x^11 + x^8 + 1
            15:      m = 32'h0000_6000;   // x^15 + x^14 + 1
            17:      m = 32'h0001_2000;   // x^17 + x^14 + 1
            default: m = 32'h0000_0000;
        endcase
        return m[C_N-1:0];
    endfunction

    localparam logic [C_N-1:0] C_TAPS = tap_mask();
    localparam logic [C_N-1:0] C_SEED = C_N'(1);
`else
    localparam logic [C_N-1:0] C_SEED = '0;
`endif

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Button front end: synchroniser, debouncer and rising-edge detector.
    // Index 0 is the step button, index 1 the mode button.
    // ------------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_btn_edge;

    assign w_btn_raw = {bus.btn_mode, bus.btn_step};

    // Counts the first two post-reset cycles; until the synchronisers hold a
    // real sample their output cannot be trusted to mean "button released".
    logic [1:0] fill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= 2'd0;
        end else if (fill_q != 2'd2) begin
            fill_q <= fill_q + 2'd1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic              sync1_q;
        logic              sync2_q;
        logic              deb_q;
        logic              deb_prev_q;
        logic              armed_q;
        logic              edge_q;
        logic [C_DB_W-1:0] db_cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                deb_q      <= 1'b0;
                deb_prev_q <= 1'b0;
                armed_q    <= 1'b0;
                edge_q     <= 1'b0;
                db_cnt_q   <= '0;
            end else begin
                sync1_q <= w_btn_raw[gi];
                sync2_q <= sync1_q;

                // Accept a new level only after DEBOUNCE_CYCLES consecutive
                // cycles of disagreement; any agreement restarts the count.
                if (sync2_q == deb_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == C_DB_LAST) begin
                    deb_q    <= sync2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + C_DB_W'(1);
                end

                // A button held through reset must be seen released before
                // its next press counts, so edges are gated until a settled
                // low level has been observed.
                if ((fill_q == 2'd2) && !sync2_q && !deb_q) begin
                    armed_q <= 1'b1;
                end

                deb_prev_q <= deb_q;
                edge_q     <= deb_q & ~deb_prev_q & armed_q;
            end
        end

        assign w_btn_edge[gi] = edge_q;
    end : g_btn

    // ------------------------------------------------------------------------
    // Sweep counter next-state
    // ------------------------------------------------------------------------
    logic [C_N-1:0] cnt_q;
    logic [C_N-1:0] cnt_d;
    logic           wrap_d;

`ifdef OPSEQ_LFSR_EN
    assign cnt_d  = {cnt_q[C_N-2:0], ^(cnt_q & C_TAPS)};
    assign wrap_d = (cnt_d == C_SEED);
`else
    assign cnt_d  = cnt_q + C_N'(1);
    assign wrap_d = (cnt_q == {C_N{1'b1}});
`endif

    // ------------------------------------------------------------------------
    // Mode FSM, prescaler and registered outputs
    // ------------------------------------------------------------------------
    state_t            state_q;
    logic [C_PS_W-1:0] presc_q;
    logic              op_valid_q;
    logic              wrap_q;
    logic              w_step_evt;
    logic              w_step_edge;
    logic              w_mode_edge;

    assign w_step_edge = w_btn_edge[0];
    assign w_mode_edge = w_btn_edge[1];

    always_comb begin
        w_step_evt = 1'b0;
        if (state_q == AUTO) begin
            w_step_evt = (presc_q == C_PRESC_LAST);
        end else begin
            w_step_evt = w_step_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MANUAL;
            presc_q    <= '0;
            cnt_q      <= C_SEED;
            op_valid_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            // A step and a mode toggle in the same cycle are both honoured.
            op_valid_q <= w_step_evt;
            wrap_q     <= w_step_evt & wrap_d;
            if (w_step_evt) begin
                cnt_q <= cnt_d;
            end

            case (state_q)
                MANUAL: begin
                    presc_q <= '0;
                    if (w_mode_edge) begin
                        state_q <= AUTO;
                    end
                end
                AUTO: begin
                    if (w_mode_edge) begin
                        state_q <= MANUAL;
                        presc_q <= '0;
                    end else if (presc_q == C_PRESC_LAST) begin
                        presc_q <= '0;
                    end else begin
                        presc_q <= presc_q + C_PS_W'(1);
                    end
                end
                default: begin
                    state_q <= MANUAL;
                    presc_q <= '0;
                end
            endcase
        end
    end

    assign bus.x         = cnt_q[WIDTH-1:0];
    assign bus.y         = cnt_q[2*WIDTH-1:WIDTH];
    assign bus.c_in      = cnt_q[2*WIDTH];
    assign bus.op_valid  = op_valid_q;
    assign bus.wrap      = wrap_q;
    assign bus.mode_auto = (state_q == AUTO);

endmodule
`default_nettype wire

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
Upstream stimulus stage for the registered n-bit adder top. Turns the two board buttons into a debounced, stepped sweep of every operand/carry combination. Drives x, y and carry-in straight into the adder, with a one-cycle valid pulse per new operand set. Supports manual single-step and timed auto-step modes.

Parameters:
WIDTH, 4, operand width; legal range 2..8; counter width N = 2*WIDTH+1
DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a debounced button changes state; minimum 2
AUTO_DIV, 12000000, clock cycles between steps in AUTO mode; minimum 2

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous reset, active-high
btn_step  in  1  raw async button; rising edge advances operands in MANUAL
btn_mode  in  1  raw async button; rising edge toggles MANUAL/AUTO
x  out  WIDTH  operand A = cnt[WIDTH-1:0]
y  out  WIDTH  operand B = cnt[2*WIDTH-1:WIDTH]
c_in  out  1  carry-in = cnt[2*WIDTH]
op_valid  out  1  one-cycle pulse in the cycle new x/y/c_in first appear
mode_auto  out  1  1 = AUTO state
wrap  out  1  one-cycle pulse, coincident with op_valid, when cnt steps to its start value

Behaviour:
- Reset values, at the first edge with rst=1: cnt=0, so x=0, y=0, c_in=0. Also op_valid=0, wrap=0, mode_auto=0 (MANUAL). Debounced states=0. Prescaler=0. Synchronisers=0.
- Reset is synchronous. Asserting rst mid-sweep or mid-debounce discards all progress on the next edge. A button held through reset release needs a full debounce and does not generate an edge until it goes low and high again.
- Synchroniser: each button passes through 2 flops before use.
- Debouncer, per button:
  - Counter clears whenever the synced level equals the debounced state.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still different, the debounced state takes the synced level and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change the debounced state.
- Edge detect: the event is a one-cycle pulse when the debounced state goes 0->1. The 1->0 transition is ignored.
- FSM states MANUAL and AUTO:
  - MANUAL: step_evt = debounced step edge. A mode edge moves to AUTO and clears the prescaler.
  - AUTO: the prescaler counts 0..AUTO_DIV-1. step_evt is asserted when prescaler = AUTO_DIV-1, and the prescaler wraps to 0. Step button edges are ignored. A mode edge moves to MANUAL and clears the prescaler.
  - Mode edge and step_evt in the same cycle: the step is applied and the state also toggles.
- Stepping: step_evt at edge k loads cnt+1 (mod 2^N) at edge k. Outputs are registered, so new values and op_valid=1 are visible in cycle k+1. Latency from the debounced edge to the output is 1 cycle.
- Button latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 (edge) + 1 (output).
- Wrap: when cnt goes 2^N-1 -> 0, wrap=1 for the same single cycle as op_valid.
- op_valid and wrap are never high for two consecutive cycles. With no step they stay 0 and x/y/c_in hold.

Optional Feature:
OPSEQ_LFSR_EN
- Defined: cnt is an N-bit Fibonacci LFSR (shift left; feedback XOR of tap bits into bit 0) instead of a binary counter.
  - Reset seed: cnt=1.
  - Period: 2^N-1; all-zero is never produced.
  - wrap pulses when the next value equals the seed (1).
  - Taps, polynomial per N: 5: x^5+x^3+1; 7: x^7+x^6+1; 9: x^9+x^5+1; 11: x^11+x^9+1; 13: x^13+x^12+x^11+x^8+1; 15: x^15+x^14+1; 17: x^17+x^14+1.
  - Reset values: x=1, y=0, c_in=0.
- Undefined: binary counter as described above; no LFSR logic is instantiated.

Test Plan:
1. Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=4, AUTO_DIV=8. Apply rst for 2 cycles -> x=0, y=0, c_in=0, op_valid=0, wrap=0, mode_auto=0.
2. btn_step high for 3 cycles then low -> no op_valid and cnt stays 0. Then hold btn_step high for 10 cycles -> exactly one op_valid pulse with x=1, y=0, c_in=0, 2+4+1+1 cycles after the rising edge.
3. Force cnt to 511 via 511 debounced presses, then one more press -> x=0, y=0, c_in=0, op_valid=1 and wrap=1 in the same single cycle.
4. Mode press -> mode_auto=1. Then op_valid every 8 cycles with x counting 1,2,3...; step presses during AUTO cause no extra pulses. A second mode press -> mode_auto=0 and pulses stop.
5. Mode debounced edge coincides with the auto prescaler terminal count -> cnt increments once, op_valid=1, mode_auto=0 in the same output cycle.
6. With OPSEQ_LFSR_EN: after reset x=1. 511 auto steps visit 511 distinct nonzero {c_in,y,x} values; the 511th step returns to 1 with wrap=1. Assert rst mid-sweep -> x=1 on the next cycle.
